// File: rtl/edge_period_meter_if.sv
// Bundles the measurement controls and period results of edge_period_meter.
// The master side drives the level and enable; the slave (the meter) returns results.
interface edge_period_meter_if #(
    parameter int CW = 32
);
    logic          en;
    logic          din;
    logic [CW-1:0] period;
    logic          period_valid;
    logic [CW-1:0] period_avg;
    logic          avg_valid;
    logic          stalled;

    modport master (
        output en, din,
        input  period, period_valid, period_avg, avg_valid, stalled
    );

    modport slave (
        input  en, din,
        output period, period_valid, period_avg, avg_valid, stalled
    );
endinterface

// File: rtl/edge_period_meter.sv
// Measures clk cycles between rising edges of a clean comparator level, reports each
// period, a block average over 2^AVG_LOG2 periods, and a stalled flag when edges stop.
module edge_period_meter #(
    parameter int CW       = 32,
    parameter int AVG_LOG2 = 2,
    parameter int TIMEOUT  = 1000000
) (
    input  logic               clk,
    input  logic               rst,
    edge_period_meter_if.slave bus
);
    localparam int            SW   = CW + AVG_LOG2;
    localparam int            NW   = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
    localparam logic [NW-1:0] LAST = NW'((1 << AVG_LOG2) - 1);
    localparam logic [CW-1:0] TMO  = CW'(TIMEOUT);

    typedef enum logic [1:0] {
        IDLE,
        ARM,
        MEAS
    } state_t;

    state_t        state;
    state_t        state_nx;
    logic          din_d;
    logic          rise;
    logic          timeout;
    logic          last_sample;
    logic [CW-1:0] cnt;
    logic [SW-1:0] sum;
    logic [SW-1:0] sum_nx;
    logic [NW-1:0] nsamp;

    assign rise        = bus.din & ~din_d;
    assign timeout     = (state == MEAS) && (cnt == TMO) && !rise;
    assign sum_nx      = sum + SW'(cnt);
    assign last_sample = (nsamp == LAST);

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    // NOTE: state_nx gets its default before the case so no path can infer a latch.
    always_comb begin
        state_nx = state;
        if (!bus.en) begin
            state_nx = IDLE;
        end else begin
            case (state)
                IDLE:    state_nx = ARM;
                ARM:     if (rise) state_nx = MEAS;
                MEAS:    if (timeout) state_nx = ARM;
                default: state_nx = IDLE;
            endcase
        end
    end

    // NOTE: non-blocking assignments keep every register sampling pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            din_d            <= 1'b1;
            cnt              <= '0;
            sum              <= '0;
            nsamp            <= '0;
            bus.period       <= '0;
            bus.period_valid <= 1'b0;
            bus.period_avg   <= '0;
            bus.avg_valid    <= 1'b0;
            bus.stalled      <= 1'b0;
        end else begin
            din_d            <= bus.din;
            bus.period_valid <= 1'b0;
            bus.avg_valid    <= 1'b0;
            // Disable beats any coincident edge; partial windows are dropped.
            if (!bus.en || state == IDLE) begin
                cnt   <= '0;
                sum   <= '0;
                nsamp <= '0;
            end else if (state == ARM) begin
                if (rise) cnt <= CW'(1);
            end else if (rise) begin
                cnt              <= CW'(1);
                bus.period       <= cnt;
                bus.period_valid <= 1'b1;
                bus.stalled      <= 1'b0;
                if (last_sample) begin
                    bus.period_avg <= CW'(sum_nx >> AVG_LOG2);
                    bus.avg_valid  <= 1'b1;
                    sum            <= '0;
                    nsamp          <= '0;
                end else begin
                    sum   <= sum_nx;
                    nsamp <= nsamp + 1'b1;
                end
            end else if (timeout) begin
                bus.stalled <= 1'b1;
                cnt         <= '0;
                sum         <= '0;
                nsamp       <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_edge_period_meter.sv
// Directed bench for edge_period_meter: period, averaging, stall, enable and reset
// behaviour checked against hand-computed values.
module tb_edge_period_meter;
    logic clk;
    logic rst;
    int   total  = 0;
    int   passed = 0;
    int   failed = 0;

    edge_period_meter_if #(.CW(32)) bus ();

    edge_period_meter #(
        .CW      (32),
        .AVG_LOG2(2),
        .TIMEOUT (1000)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Inputs change and outputs are sampled 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rise();
        bus.din = 1'b1;
        tick();
    endtask

    task automatic low(input int n);
        logic seen;
        seen    = 1'b0;
        bus.din = 1'b0;
        for (int i = 0; i < n; i++) begin
            tick();
            seen = seen | bus.period_valid | bus.avg_valid;
        end
        check($sformatf("no_pulse_over_%0d", n), seen, 0);
    endtask

    task automatic period_step(input int p, input bit exp_avg, input int avg_val);
        low(p - 1);
        rise();
        check($sformatf("period_valid_%0d", p), bus.period_valid, 1);
        check($sformatf("period_%0d", p), bus.period, p);
        check($sformatf("avg_valid_%0d", p), bus.avg_valid, exp_avg);
        if (exp_avg) check($sformatf("period_avg_%0d", p), bus.period_avg, avg_val);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_period"}, bus.period, 0);
        check({tag, "_period_avg"}, bus.period_avg, 0);
        check({tag, "_period_valid"}, bus.period_valid, 0);
        check({tag, "_avg_valid"}, bus.avg_valid, 0);
        check({tag, "_stalled"}, bus.stalled, 0);
    endtask

    initial begin
        rst     = 1'b1;
        bus.en  = 1'b0;
        bus.din = 1'b0;
        tick();
        tick();
        check_all_zero("reset");

        // Steady 100-cycle square wave, then the 98/102/100/101 window.
        rst    = 1'b0;
        bus.en = 1'b1;
        low(3);
        rise();
        check("first_edge_silent", bus.period_valid, 0);
        for (int i = 0; i < 4; i++) period_step(100, i == 3, 100);
        check("steady_not_stalled", bus.stalled, 0);
        period_step(98, 1'b0, 0);
        period_step(102, 1'b0, 0);
        period_step(100, 1'b0, 0);
        period_step(101, 1'b1, 100);

        // Two 200-cycle periods, then silence until the stall fires at exactly 1000.
        period_step(200, 1'b0, 0);
        period_step(200, 1'b0, 0);
        low(999);
        check("stall_not_yet", bus.stalled, 0);
        tick();
        check("stall_at_1000", bus.stalled, 1);
        check("stall_period_held", bus.period, 200);
        check("stall_avg_held", bus.period_avg, 100);
        rise();
        check("rearm_edge_silent", bus.period_valid, 0);
        check("rearm_still_stalled", bus.stalled, 1);
        period_step(50, 1'b0, 0);
        check("stall_cleared", bus.stalled, 0);
        period_step(50, 1'b0, 0);
        period_step(50, 1'b0, 0);
        period_step(50, 1'b1, 50);

        // Two samples into a window, disable with a coincident edge, then re-enable.
        period_step(60, 1'b0, 0);
        period_step(60, 1'b0, 0);
        low(5);
        bus.en  = 1'b0;
        bus.din = 1'b1;
        tick();
        check("en_fall_edge_ignored", bus.period_valid, 0);
        low(10);
        check("disabled_period_held", bus.period, 60);
        check("disabled_avg_held", bus.period_avg, 50);
        bus.en = 1'b1;
        low(3);
        rise();
        check("reenable_edge_silent", bus.period_valid, 0);
        period_step(80, 1'b0, 0);
        period_step(80, 1'b0, 0);
        period_step(80, 1'b0, 0);
        period_step(80, 1'b1, 80);

        // Edge landing exactly on cnt==TIMEOUT is measured, not stalled.
        period_step(1000, 1'b0, 0);
        check("edge_at_timeout_no_stall", bus.stalled, 0);

        // Stall, re-arm, then reset mid-period; a 30-cycle period follows.
        low(1000);
        check("pre_reset_stalled", bus.stalled, 1);
        rise();
        low(10);
        rst = 1'b1;
        tick();
        check_all_zero("mid_reset");
        rst = 1'b0;
        low(3);
        rise();
        check("post_reset_first_edge", bus.period_valid, 0);
        period_step(30, 1'b0, 0);

        // din already high when reset releases must not count as an edge.
        rst     = 1'b1;
        bus.din = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            check($sformatf("held_high_silent_%0d", i), bus.period_valid, 0);
        end
        low(3);
        rise();
        check("first_genuine_edge_silent", bus.period_valid, 0);
        period_step(64, 1'b0, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/edge_period_meter.md
Name: edge_period_meter

Overview:
- Consumes the 1-bit output Q of the Schmitt-trigger stage, a clean comparator level in the same clock domain.
- Measures the number of clk cycles between consecutive rising edges (signal period).
- Produces a per-period result and an average over 2^AVG_LOG2 periods, plus a stalled flag when edges stop.
- Result feeds the frequency display/reporting logic downstream.

Parameters:
- CW, 32: width of the period counter and the period outputs.
- AVG_LOG2, 2: log2 of the number of periods averaged (default N=4).
- TIMEOUT, 1000000: cycles without a rising edge before stalled is raised; must be ≤ 2^CW-1.

Ports:
- clk  input  1  system clock (100 MHz).
- rst  input  1  synchronous, active-high reset.
- en  input  1  measurement enable; low forces IDLE.
- din  input  1  Schmitt-trigger output level.
- period  output  CW  last measured period in clk cycles.
- period_valid  output  1  one-cycle pulse when period updates.
- period_avg  output  CW  mean of the last N periods, truncated.
- avg_valid  output  1  one-cycle pulse when period_avg updates.
- stalled  output  1  level; no edge seen within TIMEOUT cycles.

Behaviour:
- Interface: one clock, clk. Reset rst is synchronous and active-high. All outputs are registered.
- Reset values:
  - period=0, period_avg=0.
  - period_valid=0, avg_valid=0, stalled=0.
  - din_d=1, internal cnt=0, sum=0, sample count=0, state=IDLE.
- Edge detect: rise = din & ~din_d; din_d <= din every cycle. Because din_d resets to 1, a din that is already high at reset release is not treated as an edge.
- State IDLE:
  - cnt, sum and sample count held at 0.
  - Go to ARM when en=1.
- State ARM (waiting for the first edge, no reference yet):
  - On rise: cnt<=1, go to MEAS.
  - No output updates in this state.
- State MEAS:
  - No rise: cnt<=cnt+1.
  - On rise: period<=cnt; period_valid=1 for that one cycle; cnt<=1; stalled<=0.
  - Consequence: edges at cycles t and t+P give period=P. Minimum measurable period is 2.
- Timeout: in MEAS, if cnt==TIMEOUT and there is no rise in that cycle:
  - stalled<=1, go to ARM, cnt<=0.
  - sum and sample count cleared; period and period_avg hold their values.
  - Because cnt never exceeds TIMEOUT, the counter cannot wrap.
- Averaging: each period_valid adds period to sum (width CW+AVG_LOG2, no overflow possible).
  - On the N-th sample: period_avg <= (sum + current period) >> AVG_LOG2 (truncating); avg_valid pulses in the same cycle as that period_valid; sum and count clear.
  - Windows are non-overlapping blocks of N.
- en deassert (any state): go to IDLE next cycle.
  - cnt, sum and count cleared.
  - Outputs hold their values; no valid pulses.
  - stalled holds.
  - Re-enable restarts from ARM, so the first period after enable is only counted after two edges.
- Rise coincident with en falling: en wins; no measurement is emitted.
- Rise coincident with cnt==TIMEOUT: the edge wins; normal measurement, no stall.
- rst mid-measurement: all state returns to reset values in the next cycle; a partial window is discarded.

Test Plan:
1. Square wave on din, period 100 cycles, en=1 -> first period_valid at the second rising edge with period=100, then every 100 cycles. avg_valid after 4 samples with period_avg=100; stalled stays 0.
2. Periods 98, 102, 100, 101 -> period outputs in that order; on the 4th, period_avg=401>>2=100 and avg_valid coincides with the 4th period_valid.
3. TIMEOUT=1000; edges every 200 cycles, then din held low -> stalled=1 exactly 1000 cycles after the last edge; period stays 200. Resume with edges 50 apart -> no output on the first edge, period=50 on the second, stalled clears.
4. din held high through reset release, then pulses with period 64 -> no period_valid until two genuine rising edges have occurred, then period=64.
5. Mid-window (2 samples accumulated): drop en for 10 cycles, then restore with period 80 -> avg_valid only after 4 fresh samples, period_avg=80; period holds its last value while disabled.
6. Assert rst for 1 cycle mid-period -> every output returns to 0 on the next cycle; with a period of 30 afterwards, the first period_valid reports 30.
